// File: rtl/spi_sfr_seq_if.sv
// Bundles the SPI byte-slave side and the SFR register-file side of the frame sequencer.
// The sequencer uses the slave modport; whoever drives the frames and the SFR data uses master.
interface spi_sfr_seq_if;
  logic        cs_active;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic [11:0] rd_addr;
  logic        rd_en;
  logic [15:0] rd_data;

  modport slave (
    input  cs_active, rx_byte, rx_valid, rd_data,
    output tx_byte, wr_addr, wr_data, wr_en, rd_addr, rd_en
  );

  modport master (
    output cs_active, rx_byte, rx_valid, rd_data,
    input  tx_byte, wr_addr, wr_data, wr_en, rd_addr, rd_en
  );
endinterface

// File: rtl/spi_sfr_seq.sv
// SPI frame sequencer: decodes {rw,addr} header plus 16-bit data words into SFR
// write/read strobes, and returns read data as tx bytes with optional address auto-increment.
module spi_sfr_seq #(
  parameter int AUTO_INC   = 1,
  parameter int RD_LATENCY = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  spi_sfr_seq_if.slave       bus,
  output logic               o_busy,
  output logic               o_frame_err
);

  typedef enum logic [1:0] {
    S_CMD  = 2'd0,
    S_ADDR = 2'd1,
    S_DHI  = 2'd2,
    S_DLO  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_err;
  logic                  w_byte;
  logic                  w_capture;
  logic [11:0]           w_addr_inc;

  logic [11:0]           r_addr;
  logic                  r_rw;
  logic [7:0]            r_dhi;
  logic [15:0]           r_tx_buf;
  logic [7:0]            r_tx_byte;
  logic [11:0]           r_wr_addr;
  logic [15:0]           r_wr_data;
  logic                  r_wr_en;
  logic [11:0]           r_rd_addr;
  logic                  r_rd_en;
  logic                  r_busy;
  logic                  r_frame_err;
  logic [RD_LATENCY-1:0] r_rd_pipe;

  assign w_byte     = bus.cs_active & bus.rx_valid;
  assign w_capture  = r_rd_pipe[RD_LATENCY-1] & r_rw;
  assign w_addr_inc = r_addr + ((AUTO_INC != 0) ? 12'd1 : 12'd0);

  // Next-state decode; a dropped chip select overrides any byte in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    if (!bus.cs_active) begin
      w_state_nxt = S_CMD;
      w_err       = (r_state == S_ADDR) || (r_state == S_DLO);
    end else if (bus.rx_valid) begin
      case (r_state)
        S_CMD:   w_state_nxt = S_ADDR;
        S_ADDR:  w_state_nxt = S_DHI;
        S_DHI:   w_state_nxt = S_DLO;
        S_DLO:   w_state_nxt = S_DHI;
        default: w_state_nxt = S_CMD;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_CMD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Header/data capture, SFR strobes and tx byte selection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr      <= 12'h000;
      r_rw        <= 1'b0;
      r_dhi       <= 8'h00;
      r_tx_buf    <= 16'h0000;
      r_tx_byte   <= 8'h00;
      r_wr_addr   <= 12'h000;
      r_wr_data   <= 16'h0000;
      r_wr_en     <= 1'b0;
      r_rd_addr   <= 12'h000;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_rd_pipe   <= '0;
    end else begin
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_frame_err <= w_err;
      r_busy      <= (w_state_nxt != S_CMD);
      // A read still in flight when the frame ends must not leak into the next frame.
      if (!bus.cs_active) begin
        r_rd_pipe <= '0;
      end else begin
        r_rd_pipe[0] <= r_rd_en;
        for (int i = 1; i < RD_LATENCY; i++) begin
          r_rd_pipe[i] <= r_rd_pipe[i-1];
        end
      end

      if (!bus.cs_active) begin
        r_tx_byte <= 8'h00;
      end else if (w_byte) begin
        case (r_state)
          S_CMD: begin
            r_rw      <= bus.rx_byte[7];
            r_addr    <= {bus.rx_byte[3:0], 8'h00};
            r_tx_byte <= 8'h00;
          end
          S_ADDR: begin
            r_addr[7:0] <= bus.rx_byte;
            if (r_rw) begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= {r_addr[11:8], bus.rx_byte};
            end
          end
          S_DHI: begin
            r_dhi <= bus.rx_byte;
            if (r_rw) begin
              r_tx_byte <= r_tx_buf[7:0];
            end
          end
          S_DLO: begin
            r_addr <= w_addr_inc;
            if (r_rw) begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_addr_inc;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= {r_dhi, bus.rx_byte};
            end
          end
          default: r_tx_byte <= 8'h00;
        endcase
      end else if (w_capture) begin
        r_tx_buf  <= bus.rd_data;
        r_tx_byte <= bus.rd_data[15:8];
      end
    end
  end

  assign bus.tx_byte  = r_tx_byte;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.wr_en    = r_wr_en;
  assign bus.rd_addr  = r_rd_addr;
  assign bus.rd_en    = r_rd_en;
  assign o_busy       = r_busy;
  assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_spi_sfr_seq.sv
// Drives identical SPI frames into two sequencers (auto-increment with latency 2, fixed address
// with latency 3) and compares strobes, tx bytes and frame errors against a frame-level model.
module tb_spi_sfr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic [7:0]  rxb;
  logic        rxv;
  logic        busy_a, busy_b, ferr_a, ferr_b;
  logic [15:0] mem [4096];
  logic [7:0]  frm [$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [27:0] ow_a [$];
  logic [27:0] ow_b [$];
  logic [11:0] or_a [$];
  logic [11:0] or_b [$];
  int err_a, err_b, both_a, both_b;

  spi_sfr_seq_if if_a ();
  spi_sfr_seq_if if_b ();

  spi_sfr_seq #(.AUTO_INC(1), .RD_LATENCY(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(if_a.slave), .o_busy(busy_a), .o_frame_err(ferr_a));
  spi_sfr_seq #(.AUTO_INC(0), .RD_LATENCY(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(if_b.slave), .o_busy(busy_b), .o_frame_err(ferr_b));

  always #5 clk = ~clk;

  assign if_a.cs_active = cs;
  assign if_a.rx_byte   = rxb;
  assign if_a.rx_valid  = rxv;
  assign if_b.cs_active = cs;
  assign if_b.rx_byte   = rxb;
  assign if_b.rx_valid  = rxv;

  // SFR read responders: data is valid only exactly RD_LATENCY cycles after rd_en.
  logic [1:0]  ha_en = 2'b00;
  logic [11:0] ha_addr [2];
  logic [2:0]  hb_en = 3'b000;
  logic [11:0] hb_addr [3];
  always @(posedge clk) begin
    ha_en      <= {ha_en[0], if_a.rd_en};
    ha_addr[0] <= if_a.rd_addr;
    ha_addr[1] <= ha_addr[0];
    hb_en      <= {hb_en[1:0], if_b.rd_en};
    hb_addr[0] <= if_b.rd_addr;
    hb_addr[1] <= hb_addr[0];
    hb_addr[2] <= hb_addr[1];
  end
  assign if_a.rd_data = ha_en[1] ? mem[ha_addr[1]] : 16'h0BAD;
  assign if_b.rd_data = hb_en[2] ? mem[hb_addr[2]] : 16'h0BAD;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (if_a.wr_en) ow_a.push_back({if_a.wr_addr, if_a.wr_data});
    if (if_b.wr_en) ow_b.push_back({if_b.wr_addr, if_b.wr_data});
    if (if_a.rd_en) or_a.push_back(if_a.rd_addr);
    if (if_b.rd_en) or_b.push_back(if_b.rd_addr);
    if (ferr_a) err_a++;
    if (ferr_b) err_b++;
    if (if_a.wr_en && if_a.rd_en) both_a++;
    if (if_b.wr_en && if_b.rd_en) both_b++;
  endtask

  task automatic clear_obs();
    ow_a.delete(); ow_b.delete(); or_a.delete(); or_b.delete();
    err_a = 0; err_b = 0; both_a = 0; both_b = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap;
    gap = $urandom_range(6, 8);
    rxb = b;
    rxv = 1'b1;
    step();
    rxv = 1'b0;
    rxb = 8'($urandom);
    repeat (gap - 1) step();
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy_a"}, 32'(busy_a), 32'd0);
    check_eq({tag, "_busy_b"}, 32'(busy_b), 32'd0);
    check_eq({tag, "_ferr_a"}, 32'(ferr_a), 32'd0);
    check_eq({tag, "_tx_a"}, 32'(if_a.tx_byte), 32'd0);
    check_eq({tag, "_tx_b"}, 32'(if_b.tx_byte), 32'd0);
    check_eq({tag, "_wa_a"}, 32'(if_a.wr_addr), 32'd0);
    check_eq({tag, "_wd_a"}, 32'(if_a.wr_data), 32'd0);
    check_eq({tag, "_we_a"}, 32'(if_a.wr_en), 32'd0);
    check_eq({tag, "_ra_a"}, 32'(if_a.rd_addr), 32'd0);
    check_eq({tag, "_re_a"}, 32'(if_a.rd_en), 32'd0);
    check_eq({tag, "_wd_b"}, 32'(if_b.wr_data), 32'd0);
  endtask

  // Frame-level model: header gives rw/base; each complete word is one access at base+w*inc.
  task automatic run_frame(input string tag);
    int n, nw, eerr;
    logic rw;
    logic [11:0] base, aa;
    logic [7:0] xa, xb;
    logic [27:0] xw_a [$];
    logic [27:0] xw_b [$];
    logic [11:0] xr_a [$];
    logic [11:0] xr_b [$];
    n    = frm.size();
    rw   = (n > 0) ? frm[0][7] : 1'b0;
    base = (n > 1) ? {frm[0][3:0], frm[1]} : 12'h000;
    nw   = (n > 2) ? (n - 2) / 2 : 0;
    eerr = ((n == 1) || (n >= 2 && ((n - 2) % 2 == 1))) ? 1 : 0;
    if (n >= 2) begin
      for (int w = 0; w <= nw; w++) begin
        if (rw) begin
          xr_a.push_back(base + 12'(w));
          xr_b.push_back(base);
        end else if (w < nw) begin
          xw_a.push_back({base + 12'(w), frm[2 + 2*w], frm[3 + 2*w]});
          xw_b.push_back({base, frm[2 + 2*w], frm[3 + 2*w]});
        end
      end
    end
    clear_obs();
    cs = 1'b1;
    step(); step();
    for (int k = 0; k < n; k++) begin
      xa = 8'h00;
      xb = 8'h00;
      if (rw && k >= 2) begin
        aa = base + 12'((k - 2) / 2);
        xa = ((k - 2) % 2 == 0) ? mem[aa][15:8] : mem[aa][7:0];
        xb = ((k - 2) % 2 == 0) ? mem[base][15:8] : mem[base][7:0];
      end
      check_eq($sformatf("%s_busy_a_b%0d", tag, k), 32'(busy_a), 32'(k > 0));
      check_eq($sformatf("%s_busy_b_b%0d", tag, k), 32'(busy_b), 32'(k > 0));
      check_eq($sformatf("%s_tx_a_b%0d", tag, k), 32'(if_a.tx_byte), 32'(xa));
      check_eq($sformatf("%s_tx_b_b%0d", tag, k), 32'(if_b.tx_byte), 32'(xb));
      send_byte(frm[k]);
    end
    cs = 1'b0;
    step(); step(); step();
    check_eq({tag, "_nwr_a"}, 32'(ow_a.size()), 32'(xw_a.size()));
    check_eq({tag, "_nwr_b"}, 32'(ow_b.size()), 32'(xw_b.size()));
    check_eq({tag, "_nrd_a"}, 32'(or_a.size()), 32'(xr_a.size()));
    check_eq({tag, "_nrd_b"}, 32'(or_b.size()), 32'(xr_b.size()));
    for (int i = 0; i < ow_a.size() && i < xw_a.size(); i++)
      check_eq($sformatf("%s_wr_a%0d", tag, i), 32'(ow_a[i]), 32'(xw_a[i]));
    for (int i = 0; i < ow_b.size() && i < xw_b.size(); i++)
      check_eq($sformatf("%s_wr_b%0d", tag, i), 32'(ow_b[i]), 32'(xw_b[i]));
    for (int i = 0; i < or_a.size() && i < xr_a.size(); i++)
      check_eq($sformatf("%s_rd_a%0d", tag, i), 32'(or_a[i]), 32'(xr_a[i]));
    for (int i = 0; i < or_b.size() && i < xr_b.size(); i++)
      check_eq($sformatf("%s_rd_b%0d", tag, i), 32'(or_b[i]), 32'(xr_b[i]));
    check_eq({tag, "_ferr_a"}, 32'(err_a), 32'(eerr));
    check_eq({tag, "_ferr_b"}, 32'(err_b), 32'(eerr));
    check_eq({tag, "_both_a"}, 32'(both_a), 32'd0);
    check_eq({tag, "_both_b"}, 32'(both_b), 32'd0);
    check_eq({tag, "_end_busy_a"}, 32'(busy_a), 32'd0);
    check_eq({tag, "_end_tx_a"}, 32'(if_a.tx_byte), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[12'h010] = 16'hBEEF;
    rst = 1'b1; cs = 1'b0; rxb = 8'h00; rxv = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_idle("reset");

    frm = '{8'h00, 8'h01, 8'h00, 8'h0A};               run_frame("wr1");
    frm = '{8'h0F, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78}; run_frame("wrap");
    frm = '{8'h80, 8'h10, 8'h00, 8'h00};               run_frame("rd");
    frm = '{8'h00, 8'h02, 8'hAA};                      run_frame("part");
    frm = '{8'h80, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04}; run_frame("rdfix");
    frm = '{8'h05};                                    run_frame("hdr1");

    for (int f = 0; f < 20; f++) begin
      int n;
      frm.delete();
      n = $urandom_range(0, 9);
      for (int j = 0; j < n; j++) frm.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", f));
    end

    // Reset in the middle of a write frame, then a clean frame afterwards.
    frm = '{8'h00, 8'h07, 8'hC3, 8'h3C}; run_frame("prerst");
    clear_obs();
    cs = 1'b1;
    step(); step();
    send_byte(8'h00);
    send_byte(8'h03);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("midrst");
    step(); step();
    cs = 1'b0;
    step(); step(); step();
    check_eq("midrst_nwr", 32'(ow_a.size() + ow_b.size()), 32'd0);
    check_eq("midrst_ferr", 32'(err_a + err_b), 32'd0);
    frm = '{8'h00, 8'h03, 8'h00, 8'h05}; run_frame("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
